// File: rtl/sram_burst_ctrl.sv
// Burst initiator for a single-port synchronous SRAM with 1-cycle read latency.
// Write beats stream straight into the array; read beats return through a 2-entry buffer.
module sram_burst_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 52,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sram_cs_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int CNT_WIDTH = LEN_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{LEN_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  iss_left_q, iss_left_d;  // beats still to write or issue
  logic [CNT_WIDTH-1:0]  out_left_q, out_left_d;  // read beats still to hand out
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

  logic                  wr_hs;
  logic                  rd_hs;
  logic                  rd_issue;
  logic [1:0]            pending;

  // Handshake detection and the read-issue credit decision.
  always_comb begin
    wr_hs    = (state_q == WRITE) && wr_valid_i;
    rd_hs    = (occ_q != 2'd0) && rd_ready_i;
    pending  = occ_q + {1'b0, inflight_q};
    rd_issue = (state_q == READ) && (iss_left_q != CNT_ZERO) &&
               ((pending < 2'd2) || ((pending == 2'd2) && rd_hs));
  end

  // Next-state logic for the burst sequencer and counters.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    iss_left_d = iss_left_q;
    out_left_d = out_left_q;
    done_d     = 1'b0;
    inflight_d = rd_issue;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d     = cmd_addr_i;
          iss_left_d = {1'b0, cmd_len_i} + CNT_ONE;
          out_left_d = {1'b0, cmd_len_i} + CNT_ONE;
          state_d    = cmd_we_i ? WRITE : READ;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (wr_hs) begin
          addr_d     = addr_q + ADDR_ONE;
          iss_left_d = iss_left_q - CNT_ONE;
          if (iss_left_q == CNT_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WRITE;
          end
        end else begin
          state_d = WRITE;
        end
      end
      READ: begin
        if (rd_issue) begin
          addr_d     = addr_q + ADDR_ONE;
          iss_left_d = iss_left_q - CNT_ONE;
        end else begin
          addr_d = addr_q;
        end
        if (rd_hs) begin
          out_left_d = out_left_q - CNT_ONE;
          if (out_left_q == CNT_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read buffer: buf0 is always the head; returning data lands behind it.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({inflight_q, rd_hs})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          buf0_d = sram_rdata_i;
        end else begin
          buf1_d = sram_rdata_i;
        end
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        buf0_d = buf1_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = sram_rdata_i;
        end else begin
          buf0_d = buf1_q;
          buf1_d = sram_rdata_i;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Control state with synchronous active-low reset; an abort drops any in-flight read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= ADDR_ZERO;
      iss_left_q <= CNT_ZERO;
      out_left_q <= CNT_ZERO;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      iss_left_q <= iss_left_d;
      out_left_q <= out_left_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      done_q     <= done_d;
    end
  end

  // Buffer payload carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

  // Array strobes are gated by rst_n so nothing reaches the SRAM on a reset edge.
  always_comb begin
    cmd_ready_o  = rst_n && (state_q == IDLE);
    wr_ready_o   = rst_n && (state_q == WRITE);
    busy_o       = (state_q != IDLE);
    done_o       = done_q;
    rd_valid_o   = (occ_q != 2'd0);
    rd_data_o    = buf0_q;
    sram_cs_o    = rst_n && (wr_hs || rd_issue);
    sram_we_o    = rst_n && wr_hs;
    sram_addr_o  = addr_q;
    sram_wdata_o = wr_data_i;
  end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Randomized bench for sram_burst_ctrl: SRAM model plus a scoreboard of the burst
// contents the bench itself wrote, checked beat by beat.
module tb_sram_burst_ctrl;
  localparam int AW = 14;
  localparam int DW = 52;
  localparam int LW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [DW-1:0] wr_data, rd_data;
  logic          busy, done, sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  sram_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .busy_o(busy), .done_o(done),
    .sram_cs_o(sram_cs), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  // SRAM array with registered read data.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  // Reference: what the bench believes each address holds, and what each burst must show.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [AW-1:0] exp_wr_addr_q[$];
  logic [DW-1:0] exp_wr_data_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] wbuf [0:255];
  bit            tog [0:5];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, c0_cyc = 0, beats = 0, hs_cnt = 0, issued = 0, consumed = 0;
  bit done_exp = 1'b0, in_rd = 1'b0, first_seen = 1'b0, prev_stall = 1'b0;
  bit cmd_hs_seen = 1'b0, wr_hs_seen = 1'b0, no_issue_exp = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // One clock: inputs are already set just after a negedge; observe, score, advance.
  task automatic tick();
    bit fin;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    #1;
    cyc++;
    fin = 1'b0;
    cmd_hs_seen = 1'b0;
    wr_hs_seen  = 1'b0;
    check_eq("done", {63'd0, done}, {63'd0, done_exp});
    if (!rst_n) begin
      check_eq("cmd_ready_in_reset", {63'd0, cmd_ready}, 64'd0);
      prev_stall = 1'b0;
    end else begin
      if (done_exp) begin
        check_eq("busy_at_done", {63'd0, busy}, 64'd0);
        check_eq("cmd_ready_at_done", {63'd0, cmd_ready}, 64'd1);
      end
      if (prev_stall) begin
        check_eq("rd_hold_valid", {63'd0, rd_valid}, 64'd1);
        check_eq("rd_hold_data", {12'd0, rd_data}, {12'd0, prev_data});
      end
      if (no_issue_exp) check_eq("stall_no_issue", {63'd0, sram_cs}, 64'd0);
      if (sram_cs && sram_we) begin
        check_eq("wr_only_on_hs", {63'd0, wr_valid && wr_ready}, 64'd1);
        check_eq("wr_pending", {63'd0, exp_wr_addr_q.size() != 0}, 64'd1);
        if (exp_wr_addr_q.size() != 0) begin
          ea = exp_wr_addr_q.pop_front();
          ed = exp_wr_data_q.pop_front();
          check_eq("wr_addr", {50'd0, sram_addr}, {50'd0, ea});
          check_eq("wr_data", {12'd0, sram_wdata}, {12'd0, ed});
        end
      end
      if (sram_cs && !sram_we) begin
        issued++;
      end
      if (wr_valid && wr_ready) begin
        wr_hs_seen = 1'b1;
        hs_cnt++;
        if (hs_cnt == beats) fin = 1'b1;
      end
      if (in_rd && rd_valid && !first_seen) begin
        first_seen = 1'b1;
        check_eq("rd_latency", 64'(cyc - c0_cyc), 64'd3);
      end
      if (rd_valid && rd_ready) begin
        consumed++;
        check_eq("rd_pending", {63'd0, exp_rd_q.size() != 0}, 64'd1);
        if (exp_rd_q.size() != 0) begin
          ed = exp_rd_q.pop_front();
          check_eq("rd_data", {12'd0, rd_data}, {12'd0, ed});
        end
        if (consumed == beats) fin = 1'b1;
      end
      if (sram_cs && !sram_we) check_eq("rd_outstanding_le2", {63'd0, (issued - consumed) <= 2}, 64'd1);
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (cmd_valid && cmd_ready) begin
        cmd_hs_seen = 1'b1;
        c0_cyc = cyc;
      end
    end
    done_exp = fin;
    @(negedge clk);
  endtask

  task automatic send_cmd(input bit we, input logic [AW-1:0] a, input int len);
    int guard;
    beats = len + 1; hs_cnt = 0; issued = 0; consumed = 0;
    in_rd = !we; first_seen = 1'b0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = LW'(len);
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!cmd_hs_seen && guard < 50);
    cmd_valid = 1'b0;
    check_eq("cmd_accept", {63'd0, cmd_hs_seen}, 64'd1);
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input int len, input int vmode);
    logic [AW-1:0] t;
    int idx, pat, guard;
    bit v;
    for (int i = 0; i <= len; i++) begin
      t = a + AW'(i);
      exp_wr_addr_q.push_back(t);
      exp_wr_data_q.push_back(wbuf[i]);
      ref_mem[t] = wbuf[i];
    end
    send_cmd(1'b1, a, len);
    idx = 0; pat = 0; guard = 0;
    while (idx <= len && guard < 4000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 3) != 0);
        default: v = tog[pat % 6];
      endcase
      wr_valid = v;
      wr_data  = v ? wbuf[idx] : rnd_word();
      tick();
      if (wr_hs_seen) idx++;
      pat++; guard++;
    end
    wr_valid = 1'b0;
    check_eq("wr_beats", 64'(idx), 64'(len + 1));
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input int len, input int rmode);
    logic [AW-1:0] t;
    int guard, stall;
    bit started;
    for (int i = 0; i <= len; i++) begin
      t = a + AW'(i);
      exp_rd_q.push_back(ref_mem[t]);
    end
    send_cmd(1'b0, a, len);
    started = 1'b0; stall = 0; guard = 0;
    while (consumed <= len && guard < 4000) begin
      no_issue_exp = 1'b0;
      case (rmode)
        0: rd_ready = 1'b1;
        1: rd_ready = ($urandom_range(0, 1) != 0);
        default: begin
          if (consumed >= 2 && !started) begin
            started = 1'b1;
            stall = 5;
          end
          if (stall > 0) begin
            rd_ready = 1'b0;
            no_issue_exp = (stall < 5);
            stall--;
          end else begin
            rd_ready = 1'b1;
          end
        end
      endcase
      tick();
      guard++;
    end
    rd_ready = 1'b0; no_issue_exp = 1'b0;
    check_eq("rd_beats", 64'(consumed), 64'(len + 1));
  endtask

  initial begin
    int guard;
    logic [AW-1:0] ra;
    int rl;
    tog[0] = 1'b1; tog[1] = 1'b0; tog[2] = 1'b1; tog[3] = 1'b1; tog[4] = 1'b0; tog[5] = 1'b1;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    tick();
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check_eq("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    check_eq("rst_sram_cs", {63'd0, sram_cs}, 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check_eq("idle_busy", {63'd0, busy}, 64'd0);
    check_eq("idle_done", {63'd0, done}, 64'd0);
    check_eq("idle_rd_valid", {63'd0, rd_valid}, 64'd0);
    check_eq("idle_wr_ready", {63'd0, wr_ready}, 64'd0);
    check_eq("idle_sram_cs", {63'd0, sram_cs}, 64'd0);
    check_eq("idle_sram_we", {63'd0, sram_we}, 64'd0);

    // Basic write then read back.
    for (int i = 0; i < 4; i++) wbuf[i] = DW'(32'hA0 + i);
    write_burst(14'h0010, 3, 0);
    read_burst(14'h0010, 3, 0);

    // Maximum-length burst across the address wrap, random handshakes.
    for (int i = 0; i < 256; i++) wbuf[i] = rnd_word();
    write_burst(14'h3F80, 255, 1);
    read_burst(14'h3F80, 255, 1);

    // Backpressure on an 8-beat read.
    read_burst(14'h0020, 7, 2);

    // Wrap with gapped write data.
    for (int i = 0; i < 4; i++) wbuf[i] = rnd_word();
    write_burst(14'h3FFE, 3, 2);
    read_burst(14'h3FFE, 3, 0);

    // Reset in the middle of a 6-beat read.
    for (int i = 0; i < 6; i++) exp_rd_q.push_back(ref_mem[14'h0040 + 14'(i)]);
    send_cmd(1'b0, 14'h0040, 5);
    guard = 0;
    while (consumed < 2 && guard < 100) begin
      rd_ready = 1'b1;
      tick();
      guard++;
    end
    check_eq("pre_reset_beats", 64'(consumed), 64'd2);
    rd_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_rd_q.delete();
    in_rd = 1'b0;
    #1;
    check_eq("abort_rd_valid", {63'd0, rd_valid}, 64'd0);
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_done", {63'd0, done}, 64'd0);
    check_eq("abort_sram_cs", {63'd0, sram_cs}, 64'd0);
    read_burst(14'h0040, 0, 0);

    // Random bursts, each written then read back.
    for (int r = 0; r < 10; r++) begin
      ra = AW'($urandom_range(0, (1 << AW) - 1));
      rl = $urandom_range(0, 20);
      for (int i = 0; i <= rl; i++) wbuf[i] = rnd_word();
      write_burst(ra, rl, $urandom_range(0, 2));
      read_burst(ra, rl, $urandom_range(0, 1));
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
